// File: rtl/imem_boot_loader.sv
// ----------------------------------------------------------------------------
// imem_boot_loader
//
// Boot-time program loader for the sequential RISC-V core. A byte stream
// arriving over a valid/ready handshake is packed little-endian into 32-bit
// instruction words. Each word is written to instruction memory at
// consecutive word addresses. The core is held in reset until the
// end-of-program word 0x00000000 has been written.
//
// Ports:
//   clk          system clock, rising-edge active
//   reset        asynchronous active-high reset
//   in_valid     source presents a byte on in_data
//   in_data      program byte
//   in_ready     loader accepts a byte this cycle
//   imem_we      instruction-memory write strobe, one cycle per word
//   imem_addr    word address of the current write
//   imem_wdata   assembled instruction word
//   core_reset   processor reset; 1 while loading or after an overflow
//   load_done    terminator written; program loaded
//   word_count   words written so far, terminator included
//   overflow_err capacity exhausted before a terminator arrived
// ----------------------------------------------------------------------------
module imem_boot_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_reset,
    output logic                  load_done,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  overflow_err
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MAX_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE = (ADDR_WIDTH + 1)'(1);

    state_t     state_reg;
    logic [1:0] byte_idx_reg;

    // All outputs are registered and updated together with the state, so the
    // handshake and write strobe always agree with the current state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= LOAD;
            byte_idx_reg <= 2'd0;
            imem_addr    <= '0;
            imem_wdata   <= 32'd0;
            imem_we      <= 1'b0;
            in_ready     <= 1'b1;
            core_reset   <= 1'b1;
            load_done    <= 1'b0;
            word_count   <= '0;
            overflow_err <= 1'b0;
        end else begin
            case (state_reg)
                LOAD: begin
                    if (in_valid && in_ready) begin
                        // Little-endian packing: the first byte lands in bits 7:0.
                        imem_wdata[8*byte_idx_reg +: 8] <= in_data;
                        byte_idx_reg <= byte_idx_reg + 2'd1;
                        if (byte_idx_reg == 2'd3) begin
                            // Word complete: stall the source for the write cycle.
                            state_reg <= WRITE;
                            in_ready  <= 1'b0;
                            imem_we   <= 1'b1;
                        end
                    end
                end

                WRITE: begin
                    imem_we    <= 1'b0;
                    word_count <= word_count + COUNT_ONE;
                    if (imem_wdata == 32'd0) begin
                        // Terminator takes priority over the capacity check, so a
                        // terminator in the last slot still releases the core.
                        state_reg  <= DONE;
                        core_reset <= 1'b0;
                        load_done  <= 1'b1;
                    end else if (imem_addr == LAST_ADDR) begin
                        // Address is held at the last slot; it never wraps.
                        state_reg    <= ERROR;
                        overflow_err <= 1'b1;
                    end else begin
                        state_reg <= LOAD;
                        imem_addr <= imem_addr + ADDR_ONE;
                        in_ready  <= 1'b1;
                    end
                end

                DONE: begin
                    // Terminal until reset; incoming bytes are ignored.
                    in_ready <= 1'b0;
                    imem_we  <= 1'b0;
                end

                ERROR: begin
                    // Terminal until reset; the core stays held in reset.
                    in_ready   <= 1'b0;
                    imem_we    <= 1'b0;
                    core_reset <= 1'b1;
                end

                default: begin
                    state_reg <= ERROR;
                    in_ready  <= 1'b0;
                    imem_we   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Boot-time program loader for the sequential RISC-V core.
- Accepts a byte stream over a valid/ready interface, packs the bytes little-endian into 32-bit instruction words, and writes them to instruction memory at consecutive word addresses.
- Holds the core in reset until the end-of-program word 0x00000000 has been written. That is the same halt encoding the core's program-completion check uses.
- Sits between the host/debug byte source and the instruction-memory write port. Its core_reset output gates the processor's reset input.

Parameters:
ADDR_WIDTH, 8, instruction-memory word-address width
MAX_WORDS, 256, capacity in words; must satisfy 1 <= MAX_WORDS <= 2**ADDR_WIDTH

Ports:
clk  input  1  system clock; all state changes on the rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  source has a byte on in_data
in_data  input  8  program byte
in_ready  output  1  loader accepts a byte this cycle
imem_we  output  1  instruction-memory write strobe, one cycle per word
imem_addr  output  ADDR_WIDTH  word address of the current write
imem_wdata  output  32  assembled instruction word
core_reset  output  1  processor reset; 1 while loading or on error
load_done  output  1  terminator written; program loaded
word_count  output  ADDR_WIDTH+1  number of words written, terminator included
overflow_err  output  1  capacity exhausted without a terminator

Behaviour:
- All outputs are registered. Reset is asynchronous: the block clears immediately, not at the next edge.
- Reset values:
  - state=LOAD, byte_idx=0, imem_addr=0, imem_wdata=0, imem_we=0
  - in_ready=1, core_reset=1, load_done=0, word_count=0, overflow_err=0
- A byte transfer occurs on a rising edge where in_valid && in_ready. With in_ready=0, in_data is ignored; the source must hold its byte.
- States:
  - LOAD
    - in_ready=1, imem_we=0.
    - Each transfer writes in_data into imem_wdata[8*byte_idx+7 : 8*byte_idx], then byte_idx increments mod 4.
    - The transfer at byte_idx=3 moves the state to WRITE.
  - WRITE
    - Lasts exactly one cycle. imem_we=1, in_ready=0; imem_addr and imem_wdata are stable. word_count increments at the end of the cycle.
    - Next state:
      - imem_wdata==0 -> DONE.
      - Nonzero word and imem_addr==MAX_WORDS-1 -> ERROR.
      - Otherwise -> LOAD, with imem_addr+1.
  - DONE
    - core_reset=0, load_done=1, in_ready=0, imem_we=0.
    - Terminal until reset; incoming bytes are ignored.
  - ERROR
    - overflow_err=1, core_reset=1, in_ready=0, imem_we=0.
    - Terminal until reset.
- Timing:
  - The 4th byte is accepted at edge N. imem_we is high from edge N to edge N+1.
  - After edge N+1, in_ready=1 again, or the block is in DONE/ERROR.
  - Peak throughput is 4 bytes per 5 cycles.
- core_reset falls, and load_done rises, at the edge ending the terminator's WRITE cycle.
- The terminator is always written to memory, so the core fetches 0x00000000 at that address.
- A terminator written at address MAX_WORDS-1 leads to DONE, not ERROR.
- Reset mid-word: the partial word is discarded and no write is issued for it. imem_we drops immediately.
- imem_addr never exceeds MAX_WORDS-1, and word_count never exceeds MAX_WORDS.

Test Plan:
- Reset check: assert reset mid-cycle, sample before the next edge -> in_ready=1, core_reset=1, imem_we=0, word_count=0, load_done=0, overflow_err=0.
- Normal load: bytes 13 05 50 00 | 93 05 a0 00 | 33 06 b5 00 | 00 00 00 00 with in_valid held high ->
  - writes 0x00500513@0, 0x00a00593@1, 0x00b50633@2, 0x00000000@3;
  - each imem_we is exactly 1 cycle;
  - in_ready=0 during each write;
  - word_count=4, load_done=1, core_reset=0 after the 4th write edge.
- Gapped source: same stream with random in_valid idle cycles, and in_valid held during WRITE cycles -> identical writes, no byte dropped or duplicated.
- Overflow (MAX_WORDS=4): four nonzero words ->
  - overflow_err=1, core_reset=1, word_count=4, in_ready=0;
  - further bytes produce no imem_we.
- Reset mid-word: send 2 bytes, pulse reset, then send 13 05 50 00 -> single write 0x00500513@0, word_count=1.
- Post-done: after terminator, 8 more bytes with in_valid=1 -> in_ready stays 0, no imem_we, outputs unchanged.
